// File: rtl/cam_pixel_capture_if.sv
// cam_pixel_capture_if: camera byte stream in, frame-buffer write port out.
interface cam_pixel_capture_if #(
    parameter int ADDR_W = 17
);
    logic              vsync;
    logic              href;
    logic [7:0]        din;
    logic [ADDR_W-1:0] addr;
    logic [11:0]       dout;
    logic              we;
    logic              frame_done;

    modport master (output vsync, href, din, input addr, dout, we, frame_done);
    modport slave  (input vsync, href, din, output addr, dout, we, frame_done);
endinterface

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: packs RGB565 byte pairs into RGB444 words and writes them sequentially to the frame buffer.
module cam_pixel_capture #(
    parameter int ADDR_W     = 17,
    parameter int NUM_PIXELS = 76800
) (
    input  logic               clk,
    input  logic               rst_n,
    cam_pixel_capture_if.slave bus
);
    typedef enum logic {WAIT_FRAME, CAPTURE} state_t;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_PIXELS);

    state_t            state, next_state;
    logic              vsync_q, vs_rise, vs_fall;
    logic              phase, next_phase;
    logic [7:0]        b1, next_b1;
    logic [ADDR_W-1:0] next_addr;
    logic [11:0]       next_dout;
    logic              next_we, next_frame_done;

    assign vs_rise = !vsync_q && bus.vsync;
    assign vs_fall = vsync_q && !bus.vsync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= WAIT_FRAME;
            vsync_q        <= 1'b0;
            phase          <= 1'b0;
            b1             <= '0;
            bus.addr       <= '0;
            bus.dout       <= '0;
            bus.we         <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= next_state;
            vsync_q        <= bus.vsync;
            phase          <= next_phase;
            b1             <= next_b1;
            bus.addr       <= next_addr;
            bus.dout       <= next_dout;
            bus.we         <= next_we;
            bus.frame_done <= next_frame_done;
        end
    end

    // A vsync edge outranks any href byte sampled in the same cycle.
    always_comb begin
        next_state      = state;
        next_phase      = 1'b0;
        next_b1         = b1;
        next_addr       = bus.we ? bus.addr + ADDR_W'(1) : bus.addr;
        next_dout       = bus.dout;
        next_we         = 1'b0;
        next_frame_done = 1'b0;
        if (state == WAIT_FRAME) begin
            if (vs_fall) begin
                next_state = CAPTURE;
                next_addr  = '0;
            end
        end else if (vs_rise) begin
            next_state      = WAIT_FRAME;
            next_frame_done = 1'b1;
        end else if (bus.href) begin
            if (!phase) begin
                next_b1    = bus.din;
                next_phase = 1'b1;
            end else if ({1'b0, bus.addr} < LIMIT) begin
                next_dout = {b1[7:4], b1[2:0], bus.din[7], bus.din[4:1]};
                next_we   = 1'b1;
            end
        end
    end
endmodule
